instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL provide: CLK  in  1  sole clock, all state on rising edge.
REQ-002 SHALL provide: Reset  in  1  asynchronous, active-low reset (0 = reset).
REQ-003 SHALL provide: PCWre  in  1  PC write enable from control unit.
REQ-004 SHALL provide: PCSrc  in  2  next-PC select: 00 PC+4, 01 branch, 10 register jump, 11 absolute jump.
REQ-005 SHALL provide: IRWre  in  1  instruction-register write enable from control unit.
REQ-006 SHALL provide: ext_imm  in  32  extended immediate (branch offset, words).
REQ-007 SHALL provide: rs_data  in  32  register-file rs value (jr target).
REQ-008 SHALL provide: imem_req  out  1; imem_addr  out  32; imem_ack  in  1; imem_rdata  in  32 (variable-latency instruction memory).
REQ-009 SHALL provide: pc  out  32; pc4  out  32 (pc+4, jal link value).
REQ-010 SHALL provide: ir  out  32; op  out  6 = ir[31:26]; func  out  6 = ir[5:0]; ir_valid  out  1.
REQ-011 SHALL provide: fetch_err  out  1  misaligned-target flag (see Configuration).

Function
REQ-012 SHALL implement states BOOT, FETCH, PEND, READY, ERR.
REQ-013 BOOT SHALL move to FETCH on the first clock edge after Reset deasserts; imem_req=0 in BOOT.
REQ-014 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc; imem_addr SHALL equal pc in all states.
REQ-015 In FETCH with imem_ack=1 and IRWre=1, ir SHALL load imem_rdata, ir_valid SHALL become 1, next state READY.
REQ-016 In FETCH with imem_ack=1 and IRWre=0, a one-entry pending buffer SHALL load imem_rdata, next state PEND.
REQ-017 In PEND, imem_req SHALL be 0; on IRWre=1, ir SHALL load the buffer, ir_valid=1, next state READY.
REQ-018 In READY, ir SHALL hold; on PCWre=1, pc SHALL load next-PC, ir_valid SHALL clear, next state FETCH; PCWre and IRWre together in READY: PCWre wins, ir unchanged.
REQ-019 PCWre SHALL be ignored in BOOT, FETCH, PEND; PCWre held 0 in READY (halt) SHALL hold state indefinitely.
REQ-020 Next-PC SHALL be: 00 pc4; 01 pc4 + (ext_imm<<2); 10 rs_data; 11 {pc4[31:28], ir[25:0], 2'b00}; all sums modulo 2^32 (0xFFFFFFFC+4 = 0).
REQ-021 Zero-wait memory (ack in first FETCH cycle, IRWre=1) SHALL give ir_valid 1 on the edge after the PCWre edge +1, i.e. two edges from PC update to valid IR.
REQ-022 imem_ack outside FETCH SHALL be ignored.

Reset
REQ-023 Reset=0 SHALL immediately force: pc=0, ir=0, pending buffer=0, ir_valid=0, fetch_err=0, state BOOT; hence imem_req=0, imem_addr=0, pc4=4, op=0, func=0.
REQ-024 Reset asserted mid-fetch SHALL abandon the request; a late imem_ack after release SHALL be ignored until FETCH is re-entered.

Configuration
REQ-025 With MISALIGN_TRAP_EN defined: a PCWre update whose next-PC[1:0]!=0 SHALL load pc unmodified, set fetch_err=1 (sticky), go to ERR; ERR issues no requests, ignores all inputs, exits only by reset.
REQ-026 Without MISALIGN_TRAP_EN: next-PC[1:0] SHALL be forced to 00 on load, fetch_err SHALL be tied 0, ERR unreachable.

Verification
REQ-027 Reset release, ack on first FETCH cycle, IRWre=1, rdata=0x20080005 -> imem_addr=0, ir=0x20080005, op=0x08, ir_valid=1 two edges after release.
REQ-028 pc=0x00000010, PCSrc=01, ext_imm=0xFFFFFFFE, PCWre=1 -> pc=0x0000000C; PCSrc=11 with ir[25:0]=0x0000040 -> pc=0x00000100.
REQ-029 ack with IRWre=0, rdata=0xAC010004, IRWre=1 three cycles later -> imem_req low in PEND, ir=0xAC010004 on IRWre edge.
REQ-030 pc=0xFFFFFFFC, PCSrc=00, PCWre=1 -> pc=0x00000000; PCSrc=10, rs_data=0x00000042 -> trap build: fetch_err=1, state ERR; non-trap build: pc=0x00000040.
REQ-031 Reset pulsed while in FETCH with ack pending 3 cycles -> pc=0, ir_valid=0, imem_req=0 during reset, fetch restarts at address 0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: program counter, next-PC selection, variable-latency
// instruction memory handshake, a one-entry pending buffer and the instruction
// register.
//
// Optional feature: define MISALIGN_TRAP_EN to trap on a misaligned next-PC.
// The unit then sets a sticky fetch_err and parks in the error state until reset.
// Without it, the low two bits of the next-PC are cleared on load, and fetch_err
// is tied low.
module instr_fetch_unit (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        PCWre,
    input  logic [1:0]  PCSrc,
    input  logic        IRWre,
    input  logic [31:0] ext_imm,
    input  logic [31:0] rs_data,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic [31:0] ir,
    output logic [5:0]  op,
    output logic [5:0]  func,
    output logic        ir_valid,
    output logic        fetch_err
);

    typedef enum logic [2:0] {
        StBoot  = 3'd0,
        StFetch = 3'd1,
        StPend  = 3'd2,
        StReady = 3'd3,
        StErr   = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] buf_q, buf_d;
    logic        ir_valid_q, ir_valid_d;

    logic [31:0] pc_plus4;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] next_pc;

`ifdef MISALIGN_TRAP_EN
    logic        err_q, err_d;
    logic        misaligned;
`endif

    // Candidate targets; all arithmetic wraps modulo 2^32.
    always_comb begin
        pc_plus4      = pc_q + 32'd4;
        branch_target = pc_plus4 + (ext_imm << 2);
        jump_target   = {pc_plus4[31:28], ir_q[25:0], 2'b00};
        next_pc       = pc_plus4;
        unique case (PCSrc)
            2'b00: next_pc = pc_plus4;
            2'b01: next_pc = branch_target;
            2'b10: next_pc = rs_data;
            2'b11: next_pc = jump_target;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    // Only a register jump can produce a misaligned target, but check them all.
    always_comb begin
        misaligned = |next_pc[1:0];
    end
`endif

    // Next-state and datapath updates; a request is only issued in the fetch state.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        buf_d      = buf_q;
        ir_valid_d = ir_valid_q;
        imem_req   = 1'b0;
`ifdef MISALIGN_TRAP_EN
        err_d      = err_q;
`endif
        unique case (state_q)
            StBoot: begin
                state_d = StFetch;
            end
            StFetch: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    if (IRWre) begin
                        ir_d       = imem_rdata;
                        ir_valid_d = 1'b1;
                        state_d    = StReady;
                    end else begin
                        // Control unit not ready for the IR yet; park the word.
                        buf_d   = imem_rdata;
                        state_d = StPend;
                    end
                end
            end
            StPend: begin
                if (IRWre) begin
                    ir_d       = buf_q;
                    ir_valid_d = 1'b1;
                    state_d    = StReady;
                end
            end
            StReady: begin
                // PCWre has priority over IRWre here: the IR keeps the current word.
                if (PCWre) begin
                    ir_valid_d = 1'b0;
`ifdef MISALIGN_TRAP_EN
                    pc_d = next_pc;
                    if (misaligned) begin
                        err_d   = 1'b1;
                        state_d = StErr;
                    end else begin
                        state_d = StFetch;
                    end
`else
                    pc_d    = next_pc & ~32'd3;
                    state_d = StFetch;
`endif
                end
            end
            StErr: begin
                state_d = StErr;
            end
            default: begin
                state_d = StBoot;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously by Reset.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q    <= StBoot;
            pc_q       <= 32'd0;
            ir_q       <= 32'd0;
            buf_q      <= 32'd0;
            ir_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            buf_q      <= buf_d;
            ir_valid_q <= ir_valid_d;
        end
    end

`ifdef MISALIGN_TRAP_EN
    // Sticky misalignment flag; cleared only by reset.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign fetch_err = err_q;
`else
    assign fetch_err = 1'b0;
`endif

    assign pc        = pc_q;
    assign pc4       = pc_plus4;
    assign imem_addr = pc_q;
    assign ir        = ir_q;
    assign op        = ir_q[31:26];
    assign func      = ir_q[5:0];
    assign ir_valid  = ir_valid_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, a reset-during-fetch
// sequence, then randomized traffic checked against a flag-based reference model.
module tb_instr_fetch_unit;

`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        CLK;
    logic        Reset;
    logic        PCWre;
    logic [1:0]  PCSrc;
    logic        IRWre;
    logic [31:0] ext_imm;
    logic [31:0] rs_data;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] ir;
    logic [5:0]  op;
    logic [5:0]  func;
    logic        ir_valid;
    logic        fetch_err;

    instr_fetch_unit dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .PCWre      (PCWre),
        .PCSrc      (PCSrc),
        .IRWre      (IRWre),
        .ext_imm    (ext_imm),
        .rs_data    (rs_data),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .pc         (pc),
        .pc4        (pc4),
        .ir         (ir),
        .op         (op),
        .func       (func),
        .ir_valid   (ir_valid),
        .fetch_err  (fetch_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_vec;
    int n_bad;

    task automatic cmp(input string tag, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s.%s: got %h, want %h", tag, name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_ir,
                             input logic e_valid, input logic e_req, input logic e_err);
        logic [31:0] e_pc4;
        e_pc4 = e_pc + 32'd4;
        cmp(tag, "pc",        pc,                e_pc);
        cmp(tag, "pc4",       pc4,               e_pc4);
        cmp(tag, "imem_addr", imem_addr,         e_pc);
        cmp(tag, "ir",        ir,                e_ir);
        cmp(tag, "op",        {26'd0, op},       {26'd0, e_ir[31:26]});
        cmp(tag, "func",      {26'd0, func},     {26'd0, e_ir[5:0]});
        cmp(tag, "ir_valid",  {31'd0, ir_valid}, {31'd0, e_valid});
        cmp(tag, "imem_req",  {31'd0, imem_req}, {31'd0, e_req});
        cmp(tag, "fetch_err", {31'd0, fetch_err}, {31'd0, e_err});
    endtask

    task automatic drive(input logic pcwre, input logic [1:0] pcsrc, input logic irwre,
                         input logic ack, input logic [31:0] rdata, input logic [31:0] ext,
                         input logic [31:0] rs);
        PCWre      = pcwre;
        PCSrc      = pcsrc;
        IRWre      = irwre;
        imem_ack   = ack;
        imem_rdata = rdata;
        ext_imm    = ext;
        rs_data    = rs;
    endtask

    // Reference model: flags describing what the unit is waiting for.
    bit          m_boot, m_fetching, m_held, m_valid, m_err;
    logic [31:0] m_pc, m_ir, m_buf;

    task automatic model_reset();
        m_boot = 1'b1; m_fetching = 1'b0; m_held = 1'b0; m_valid = 1'b0; m_err = 1'b0;
        m_pc = 32'd0; m_ir = 32'd0; m_buf = 32'd0;
    endtask

    task automatic model_step();
        logic [31:0] tgt;
        if (m_err) begin
            // parked until reset
        end else if (m_boot) begin
            m_boot = 1'b0;
            m_fetching = 1'b1;
        end else if (m_fetching) begin
            if (imem_ack) begin
                m_fetching = 1'b0;
                if (IRWre) begin
                    m_ir = imem_rdata;
                    m_valid = 1'b1;
                end else begin
                    m_buf = imem_rdata;
                    m_held = 1'b1;
                end
            end
        end else if (m_held) begin
            if (IRWre) begin
                m_ir = m_buf;
                m_held = 1'b0;
                m_valid = 1'b1;
            end
        end else if (m_valid && PCWre) begin
            case (PCSrc)
                2'b00:   tgt = m_pc + 4;
                2'b01:   tgt = m_pc + 4 + ext_imm * 4;
                2'b10:   tgt = rs_data;
                default: tgt = ((m_pc + 4) & 32'hF000_0000) | ((m_ir & 32'h03FF_FFFF) * 4);
            endcase
            m_valid = 1'b0;
            if (TRAP && (tgt % 4 != 0)) begin
                m_pc = tgt;
                m_err = 1'b1;
            end else begin
                m_pc = tgt - (tgt % 4);
                m_fetching = 1'b1;
            end
        end
    endtask

    typedef struct {
        logic        pcwre;
        logic [1:0]  pcsrc;
        logic        irwre;
        logic        ack;
        logic [31:0] rdata;
        logic [31:0] ext;
        logic [31:0] rs;
        logic [31:0] e_pc;
        logic [31:0] e_ir;
        logic        e_valid;
        logic        e_req;
        logic        e_err;
    } vec_t;

    vec_t tbl [18];

    initial begin
        n_vec = 0;
        n_bad = 0;

        tbl[0]  = '{1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0,
                    32'h0, 32'h0, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 2'b00, 1'b1, 1'b1, 32'h20080005, 32'h0, 32'h0,
                    32'h0, 32'h20080005, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 2'b10, 1'b0, 1'b0, 32'h0, 32'h0, 32'h10,
                    32'h10, 32'h20080005, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 2'b00, 1'b1, 1'b1, 32'h08000040, 32'h0, 32'h0,
                    32'h10, 32'h08000040, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 2'b01, 1'b0, 1'b0, 32'h0, 32'hFFFFFFFE, 32'h0,
                    32'hC, 32'h08000040, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 2'b00, 1'b1, 1'b1, 32'h08000040, 32'h0, 32'h0,
                    32'hC, 32'h08000040, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 2'b11, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0,
                    32'h100, 32'h08000040, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 2'b00, 1'b0, 1'b1, 32'hAC010004, 32'h0, 32'h0,
                    32'h100, 32'h08000040, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 2'b00, 1'b0, 1'b1, 32'h11111111, 32'h0, 32'h0,
                    32'h100, 32'h08000040, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0,
                    32'h100, 32'h08000040, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 2'b00, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0,
                    32'h100, 32'hAC010004, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 2'b00, 1'b1, 1'b1, 32'h55555555, 32'h0, 32'h0,
                    32'h100, 32'hAC010004, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 2'b10, 1'b1, 1'b1, 32'h66666666, 32'h0, 32'hFFFFFFFC,
                    32'hFFFFFFFC, 32'hAC010004, 1'b0, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 2'b00, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0,
                    32'hFFFFFFFC, 32'h0, 1'b1, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0,
                    32'h0, 32'h0, 1'b0, 1'b1, 1'b0};
        tbl[15] = '{1'b0, 2'b00, 1'b1, 1'b1, 32'h00001234, 32'h0, 32'h0,
                    32'h0, 32'h1234, 1'b1, 1'b0, 1'b0};
`ifdef MISALIGN_TRAP_EN
        tbl[16] = '{1'b1, 2'b10, 1'b0, 1'b0, 32'h0, 32'h0, 32'h42,
                    32'h42, 32'h1234, 1'b0, 1'b0, 1'b1};
        tbl[17] = '{1'b1, 2'b00, 1'b1, 1'b1, 32'h77, 32'h0, 32'h0,
                    32'h42, 32'h1234, 1'b0, 1'b0, 1'b1};
`else
        tbl[16] = '{1'b1, 2'b10, 1'b0, 1'b0, 32'h0, 32'h0, 32'h42,
                    32'h40, 32'h1234, 1'b0, 1'b1, 1'b0};
        tbl[17] = '{1'b1, 2'b00, 1'b1, 1'b1, 32'h77, 32'h0, 32'h0,
                    32'h40, 32'h77, 1'b1, 1'b0, 1'b0};
`endif

        // Reset state
        Reset = 1'b0;
        drive(1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        repeat (2) @(negedge CLK);
        check_all("reset", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        Reset = 1'b1;

        // Directed vector table, one clock edge per row
        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].pcwre, tbl[i].pcsrc, tbl[i].irwre, tbl[i].ack, tbl[i].rdata,
                  tbl[i].ext, tbl[i].rs);
            @(posedge CLK);
            @(negedge CLK);
            check_all($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_ir, tbl[i].e_valid,
                      tbl[i].e_req, tbl[i].e_err);
        end

        // Reset pulsed during an outstanding fetch; a late ack must be ignored
        Reset = 1'b0;
        drive(1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        @(negedge CLK);
        Reset = 1'b1;
        repeat (3) begin
            @(posedge CLK);
            @(negedge CLK);
        end
        check_all("pend_fetch", 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        #2;
        Reset = 1'b0;
        #1;
        check_all("mid_reset", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        Reset = 1'b1;
        drive(1'b0, 2'b00, 1'b1, 1'b1, 32'hDEADBEEF, 32'h0, 32'h0);
        @(posedge CLK);
        @(negedge CLK);
        check_all("late_ack", 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 2'b00, 1'b1, 1'b1, 32'h3C011234, 32'h0, 32'h0);
        @(posedge CLK);
        @(negedge CLK);
        check_all("refetch", 32'h0, 32'h3C011234, 1'b1, 1'b0, 1'b0);

        // Randomized traffic against the reference model
        Reset = 1'b0;
        model_reset();
        @(negedge CLK);
        Reset = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (i % 300 == 299) begin
                Reset = 1'b0;
                model_reset();
                #1;
                check_all("rnd_reset", m_pc, m_ir, m_valid, m_fetching, m_err);
                @(negedge CLK);
                Reset = 1'b1;
            end else begin
                drive(($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)),
                      ($urandom_range(0, 1) == 1), ($urandom_range(0, 2) == 0), $urandom,
                      32'($urandom_range(0, 63)) - 32'd32,
                      ($urandom_range(0, 15) == 0) ? $urandom : ($urandom & ~32'd3));
                @(posedge CLK);
                model_step();
                @(negedge CLK);
                check_all("rnd", m_pc, m_ir, m_valid, m_fetching, m_err);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
